// File: rtl/vga_sdram_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_sdram_port_scheduler
// Purpose  : Shares the single SDRAM burst port between the camera capture
//            write FIFO and the VGA display read FIFO. Picks the side that
//            gets the next burst, generates its start address and length,
//            and keeps per-side frame pointers aligned to frame starts.
//            Pixel data never passes through this block.
// Option   : VGA_DOUBLE_BUFFER_EN - two frame banks (0 and BANK_STRIDE).
//            Writes ping-pong between banks; the display reads the bank of
//            the most recently completed write frame, so no tearing.
// Ports    : iCLK, iRST_N (sync, active-low)
//            iWR_FRAME_START / iRD_FRAME_START  frame start pulses
//            iWR_USEDW / iRD_USEDW              FIFO fill levels
//            oREQ, oREQ_WR, oADDR, oLEN         burst request to controller
//            iACK, iDONE                        controller handshake
//            oRD_URGENT                         registered low-level flag
//            oUNDERRUN                          sticky display underrun
// Revision : 1.0 - initial release
// ============================================================================
module vga_sdram_port_scheduler #(
    parameter int          BURST_LEN   = 256,
    parameter int          FRAME_WORDS = 243200,
    parameter int          RD_LOW      = 128,
    parameter int          RD_DEPTH    = 1024,
    parameter logic [22:0] BANK_STRIDE = 23'h040000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iWR_FRAME_START,
    input  logic        iRD_FRAME_START,
    input  logic [9:0]  iWR_USEDW,
    input  logic [9:0]  iRD_USEDW,
    output logic        oREQ,
    output logic        oREQ_WR,
    output logic [22:0] oADDR,
    output logic [8:0]  oLEN,
    input  logic        iACK,
    input  logic        iDONE,
    output logic        oRD_URGENT,
    output logic        oUNDERRUN
);

    localparam logic [17:0] c_BURST = 18'(BURST_LEN);
    localparam logic [17:0] c_FRAME = 18'(FRAME_WORDS);
    localparam logic [17:0] c_RDLOW = 18'(RD_LOW);
    localparam logic [17:0] c_TOPUP = 18'(RD_DEPTH - BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_REQ  = 2'd2,
        S_BUSY = 2'd3
    } state_t;

    state_t      r_state;
    logic [17:0] r_wrPtr;
    logic [17:0] r_rdPtr;
    logic        r_wrPend;
    logic        r_rdPend;
    logic        r_rdActive;

    logic        w_inArb;
    logic        w_wrStartPend;
    logic        w_rdStartPend;
    logic        w_wrApply;
    logic        w_rdApply;
    logic [17:0] w_wrPtrEff;
    logic [17:0] w_rdPtrEff;
    logic [17:0] w_wrRem;
    logic [17:0] w_rdRem;
    logic [17:0] w_wrLen;
    logic [17:0] w_rdLen;
    logic [17:0] w_wrUsed;
    logic [17:0] w_rdUsed;
    logic        w_grantRdUrg;
    logic        w_grantWr;
    logic        w_grantRdTop;
    logic [22:0] w_wrBase;
    logic [22:0] w_rdBase;
    logic [22:0] w_wrAddr;
    logic [22:0] w_rdAddr;
    logic        w_done;
    logic [17:0] w_wrAdv;
    logic [17:0] w_rdAdv;

    // Frame starts are only applied while no burst is outstanding, so a
    // start seen during REQ/BUSY waits until the burst's own advance is done.
    assign w_inArb       = (r_state == S_IDLE) || (r_state == S_ARB);
    assign w_wrStartPend = r_wrPend | iWR_FRAME_START;
    assign w_rdStartPend = r_rdPend | iRD_FRAME_START;
    assign w_wrApply     = w_inArb & w_wrStartPend;
    assign w_rdApply     = w_inArb & w_rdStartPend;

    // Arbitrate on the pointer as it will be after any frame start applied
    // this cycle, so a grant in the same cycle already targets word 0.
    assign w_wrPtrEff = w_wrApply ? 18'd0 : r_wrPtr;
    assign w_rdPtrEff = w_rdApply ? 18'd0 : r_rdPtr;
    assign w_wrRem    = c_FRAME - w_wrPtrEff;
    assign w_rdRem    = c_FRAME - w_rdPtrEff;
    assign w_wrLen    = (w_wrRem < c_BURST) ? w_wrRem : c_BURST;
    assign w_rdLen    = (w_rdRem < c_BURST) ? w_rdRem : c_BURST;
    assign w_wrUsed   = {8'd0, iWR_USEDW};
    assign w_rdUsed   = {8'd0, iRD_USEDW};

    assign w_grantRdUrg = (w_rdUsed < c_RDLOW) && (w_rdRem != 18'd0);
    assign w_grantWr    = (w_wrUsed >= w_wrLen) && (w_wrRem != 18'd0);
    assign w_grantRdTop = (w_rdUsed <= c_TOPUP) && (w_rdRem != 18'd0);

`ifdef VGA_DOUBLE_BUFFER_EN
    logic r_wrBank;
    logic r_rdBank;
    logic r_lastBank;   // bank of the most recently completed write frame
    logic w_wrBankEff;
    logic w_rdBankEff;

    assign w_wrBankEff = w_wrApply ? ~r_wrBank : r_wrBank;
    assign w_rdBankEff = w_rdApply ? r_lastBank : r_rdBank;
    assign w_wrBase    = w_wrBankEff ? BANK_STRIDE : 23'd0;
    assign w_rdBase    = w_rdBankEff ? BANK_STRIDE : 23'd0;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_wrBank   <= 1'b0;
            r_rdBank   <= 1'b0;
            r_lastBank <= 1'b0;
        end else begin
            if (w_wrApply) begin
                r_wrBank <= ~r_wrBank;
            end
            if (w_rdApply) begin
                r_rdBank <= r_lastBank;
            end
            if (w_done && oREQ_WR && (w_wrAdv == c_FRAME)) begin
                r_lastBank <= r_wrBank;
            end
        end
    end
`else
    assign w_wrBase = 23'd0;
    assign w_rdBase = 23'd0;
`endif

    assign w_wrAddr = w_wrBase + {5'd0, w_wrPtrEff};
    assign w_rdAddr = w_rdBase + {5'd0, w_rdPtrEff};

    // Completion: normal iDONE in BUSY, or iACK and iDONE together in REQ.
    assign w_done  = iDONE && ((r_state == S_BUSY) || ((r_state == S_REQ) && iACK));
    assign w_wrAdv = r_wrPtr + {9'd0, oLEN};
    assign w_rdAdv = r_rdPtr + {9'd0, oLEN};

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state    <= S_IDLE;
            r_wrPtr    <= 18'd0;
            r_rdPtr    <= 18'd0;
            r_wrPend   <= 1'b0;
            r_rdPend   <= 1'b0;
            r_rdActive <= 1'b0;
            oREQ       <= 1'b0;
            oREQ_WR    <= 1'b0;
            oADDR      <= 23'd0;
            oLEN       <= 9'd0;
            oRD_URGENT <= 1'b0;
            oUNDERRUN  <= 1'b0;
        end else begin
            oRD_URGENT <= (w_rdUsed < c_RDLOW);
            oUNDERRUN  <= oUNDERRUN | (r_rdActive && (iRD_USEDW == 10'd0));

            r_wrPend <= w_inArb ? 1'b0 : w_wrStartPend;
            r_rdPend <= w_inArb ? 1'b0 : w_rdStartPend;

            if (w_wrApply) begin
                r_wrPtr <= 18'd0;
            end else if (w_done && oREQ_WR) begin
                r_wrPtr <= w_wrAdv;
            end

            if (w_rdApply) begin
                r_rdPtr <= 18'd0;
            end else if (w_done && !oREQ_WR) begin
                r_rdPtr <= w_rdAdv;
            end

            // A display frame is in progress from its vsync until its last
            // read burst completes.
            if (iRD_FRAME_START) begin
                r_rdActive <= 1'b1;
            end else if (w_done && !oREQ_WR && (w_rdAdv == c_FRAME)) begin
                r_rdActive <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_grantRdUrg) begin
                        oREQ    <= 1'b1;
                        oREQ_WR <= 1'b0;
                        oADDR   <= w_rdAddr;
                        oLEN    <= w_rdLen[8:0];
                        r_state <= S_REQ;
                    end else if (w_grantWr) begin
                        oREQ    <= 1'b1;
                        oREQ_WR <= 1'b1;
                        oADDR   <= w_wrAddr;
                        oLEN    <= w_wrLen[8:0];
                        r_state <= S_REQ;
                    end else if (w_grantRdTop) begin
                        oREQ    <= 1'b1;
                        oREQ_WR <= 1'b0;
                        oADDR   <= w_rdAddr;
                        oLEN    <= w_rdLen[8:0];
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (iACK) begin
                        oREQ    <= 1'b0;
                        r_state <= iDONE ? S_IDLE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (iDONE) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
